// File: rtl/intra_ref_row_fetch_if.sv
// ---------------------------------------------------------------------------
// intra_ref_row_fetch_if
// Bundles the request, row-buffer port-B and pixel-output signals of
// intra_ref_row_fetch.
//   slave  : the fetch controller (consumes requests and RAM data, drives
//            status, RAM control and pixel outputs).
//   master : the surrounding logic (issues requests, hosts the row buffer,
//            consumes pixels).
// Signal summary:
//   start_i, pos_x_i, len_i, right_lmt_i, top_avail_i : fetch request
//   busy_o, done_o                                     : fetch status
//   ram_cen_o, ram_wen_o, ram_oen_o, ram_addr_o        : buffer port B control
//   ram_data_i                                         : buffer port B read data
//   pix_valid_o, pix_idx_o, pix_data_o                 : reference word output
// ---------------------------------------------------------------------------
interface intra_ref_row_fetch_if #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 6,
  parameter int LEN_W      = 5
);
  logic                  start_i;
  logic [Addr_Width-1:0] pos_x_i;
  logic [LEN_W-1:0]      len_i;
  logic [Addr_Width-1:0] right_lmt_i;
  logic                  top_avail_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  ram_cen_o;
  logic                  ram_wen_o;
  logic                  ram_oen_o;
  logic [Addr_Width-1:0] ram_addr_o;
  logic [Word_Width-1:0] ram_data_i;
  logic                  pix_valid_o;
  logic [3:0]            pix_idx_o;
  logic [Word_Width-1:0] pix_data_o;

  modport slave (
    input  start_i, pos_x_i, len_i, right_lmt_i, top_avail_i, ram_data_i,
    output busy_o, done_o, ram_cen_o, ram_wen_o, ram_oen_o, ram_addr_o,
           pix_valid_o, pix_idx_o, pix_data_o
  );

  modport master (
    output start_i, pos_x_i, len_i, right_lmt_i, top_avail_i, ram_data_i,
    input  busy_o, done_o, ram_cen_o, ram_wen_o, ram_oen_o, ram_addr_o,
           pix_valid_o, pix_idx_o, pix_data_o
  );
endinterface

// File: rtl/intra_ref_row_fetch.sv
// ---------------------------------------------------------------------------
// intra_ref_row_fetch
// Read-side controller for the LCU-row reference buffer used by intra
// prediction. On an accepted start it reads up to 16 consecutive words of the
// above row through buffer port B, clamps reads past the right picture edge
// (replicating the rightmost in-picture pixel), or emits the 8'h80 default
// when the above row is unavailable. One word per cycle is delivered with a
// valid strobe and a word index.
// Ports:
//   clk      : single clock, shared with the row buffer
//   rst      : asynchronous reset, active high
//   bus      : intra_ref_row_fetch_if.slave (request, status, RAM, pixels)
//   rd_cnt_o : [15:0] saturating count of RAM read cycles
//              (present only when INTRA_REF_ROW_CNT_EN is defined)
// Optional feature macro: INTRA_REF_ROW_CNT_EN
// Latency: READ issues its first address the cycle after accept, the buffer
// returns data one cycle later and the output register loads on the next
// edge, so the first word is valid 3 cycles after accept. FILL words start
// the cycle after accept.
// ---------------------------------------------------------------------------
module intra_ref_row_fetch #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 6,
  parameter int LEN_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  intra_ref_row_fetch_if.slave bus
`ifdef INTRA_REF_ROW_CNT_EN
  ,
  output logic [15:0]          rd_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FILL} state_t;

  localparam int SumW  = Addr_Width + 1;
  localparam int Bytes = Word_Width / 8;
  localparam logic [LEN_W-1:0] LenMax = LEN_W'(16);

  state_t                state_reg, state_next;
  logic [Addr_Width-1:0] pos_x_reg;
  logic [Addr_Width-1:0] right_lmt_reg;
  logic [LEN_W-1:0]      len_reg;
  logic [LEN_W-1:0]      k_reg;        // next word to issue (READ) or emit (FILL)

  // Stage 1: tags travelling alongside the RAM access
  logic                  s1_vld_reg;
  logic                  s1_pad_reg;
  logic                  s1_last_reg;
  logic [3:0]            s1_idx_reg;

  // Output registers
  logic                  pix_valid_reg;
  logic [3:0]            pix_idx_reg;
  logic [Word_Width-1:0] pix_data_reg;
  logic                  done_reg;

  logic                  accept;
  logic [LEN_W-1:0]      len_sat;
  logic [SumW-1:0]       rd_sum;
  logic                  rd_pad;
  logic [Addr_Width-1:0] rd_addr;
  logic                  k_last;
  logic [Word_Width-1:0] pad_word;
  logic [Word_Width-1:0] fill_word;

  assign accept  = bus.start_i && (state_reg == IDLE);
  assign len_sat = (bus.len_i > LenMax) ? LenMax : bus.len_i;

  // One extra bit on the sum so pos_x+k past the buffer end still compares
  // as beyond the right limit instead of wrapping to a small address.
  assign rd_sum  = {1'b0, pos_x_reg} + SumW'(k_reg);
  assign rd_pad  = rd_sum > {1'b0, right_lmt_reg};
  assign rd_addr = rd_pad ? right_lmt_reg : rd_sum[Addr_Width-1:0];
  assign k_last  = (k_reg == len_reg - LEN_W'(1));

  // Padded word: rightmost pixel (top byte) of the clamped read, replicated.
  generate
    for (genvar gi = 0; gi < Bytes; gi++) begin : g_bytes
      assign pad_word[gi*8 +: 8]  = bus.ram_data_i[Word_Width-1 -: 8];
      assign fill_word[gi*8 +: 8] = 8'h80;
    end
  endgenerate

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          // An empty request reuses DRAIN to spend its single busy/done cycle.
          if (len_sat == '0)         state_next = DRAIN;
          else if (!bus.top_avail_i) state_next = FILL;
          else                       state_next = READ;
        end
      end
      READ:  if (k_last)   state_next = DRAIN;
      DRAIN: if (done_reg) state_next = IDLE;
      FILL:  if (done_reg) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy_o     = (state_reg != IDLE);
    bus.ram_cen_o  = (state_reg != READ);
    bus.ram_addr_o = rd_addr;
  end

  assign bus.ram_wen_o   = 1'b1;
  assign bus.ram_oen_o   = 1'b0;
  assign bus.done_o      = done_reg;
  assign bus.pix_valid_o = pix_valid_reg;
  assign bus.pix_idx_o   = pix_idx_reg;
  assign bus.pix_data_o  = pix_data_reg;

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x_reg     <= '0;
      right_lmt_reg <= '0;
      len_reg       <= '0;
      k_reg         <= '0;
      s1_vld_reg    <= 1'b0;
      s1_pad_reg    <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_idx_reg    <= '0;
      pix_valid_reg <= 1'b0;
      pix_idx_reg   <= '0;
      pix_data_reg  <= '0;
      done_reg      <= 1'b0;
    end else begin
      s1_vld_reg    <= 1'b0;
      pix_valid_reg <= 1'b0;
      done_reg      <= 1'b0;

      if (accept) begin
        pos_x_reg     <= bus.pos_x_i;
        right_lmt_reg <= bus.right_lmt_i;
        len_reg       <= len_sat;
        k_reg         <= '0;
        if (len_sat == '0) begin
          done_reg <= 1'b1;
        end else if (!bus.top_avail_i) begin
          // First default word goes out right away, the rest from FILL.
          pix_valid_reg <= 1'b1;
          pix_data_reg  <= fill_word;
          pix_idx_reg   <= '0;
          done_reg      <= (len_sat == LEN_W'(1));
          k_reg         <= LEN_W'(1);
        end
      end

      if (state_reg == READ) begin
        s1_vld_reg  <= 1'b1;
        s1_pad_reg  <= rd_pad;
        s1_last_reg <= k_last;
        s1_idx_reg  <= k_reg[3:0];
        k_reg       <= k_reg + LEN_W'(1);
      end

      // done_reg marks the last word already out; stop emitting.
      if (state_reg == FILL && !done_reg) begin
        pix_valid_reg <= 1'b1;
        pix_data_reg  <= fill_word;
        pix_idx_reg   <= k_reg[3:0];
        done_reg      <= k_last;
        k_reg         <= k_reg + LEN_W'(1);
      end

      // RAM data for the stage-1 word is on ram_data_i this cycle.
      if (s1_vld_reg) begin
        pix_valid_reg <= 1'b1;
        pix_data_reg  <= s1_pad_reg ? pad_word : bus.ram_data_i;
        pix_idx_reg   <= s1_idx_reg;
        done_reg      <= s1_last_reg;
      end
    end
  end

`ifdef INTRA_REF_ROW_CNT_EN
  logic [15:0] rd_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         rd_cnt_reg <= '0;
    else if (state_reg == READ && rd_cnt_reg != 16'hFFFF) rd_cnt_reg <= rd_cnt_reg + 16'd1;
  end

  assign rd_cnt_o = rd_cnt_reg;
`endif

endmodule

// File: tb/tb_intra_ref_row_fetch.sv
// ---------------------------------------------------------------------------
// tb_intra_ref_row_fetch
// Table of fetch requests with expected latency and last word, a scoreboard
// of expected words and RAM addresses built from the bench's buffer model,
// plus hand-written sequences for the busy-ignore and reset-abort cases.
// ---------------------------------------------------------------------------
module tb_intra_ref_row_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  intra_ref_row_fetch_if bus ();

`ifdef INTRA_REF_ROW_CNT_EN
  logic [15:0] rd_cnt;
`endif

  intra_ref_row_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef INTRA_REF_ROW_CNT_EN
    ,
    .rd_cnt_o (rd_cnt)
`endif
  );

  // Row buffer port B: registered read, data one cycle after issue.
  logic [31:0] ram [0:63];
  logic [31:0] ram_q;
  always @(posedge clk)
    if (!bus.ram_cen_o && bus.ram_wen_o) ram_q <= ram[bus.ram_addr_o];
  assign bus.ram_data_i = ram_q;

  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          last;
  } exp_t;

  typedef struct {
    int          pos;
    int          len;
    int          rlmt;
    bit          top;
    int          lat;
    logic [31:0] last;
  } vec_t;

  exp_t exp_q[$];
  int   addr_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic run_fetch(input int pos, input int len, input int rlmt, input bit top,
                           input int exp_lat, input logic [31:0] exp_last,
                           input int extra_cyc, input int rst_word);
    int n, first, words, done_cyc, end_cyc;
    bit aborted;
    logic [31:0] last_data;
    exp_t e;
    n = (len > 16) ? 16 : len;
    exp_q.delete();
    addr_q.delete();
    for (int k = 0; k < n; k++) begin
      int a;
      a      = pos + k;
      e.idx  = k;
      e.last = (k == n - 1);
      if (!top) e.data = 32'h80808080;
      else begin
        addr_q.push_back((a > rlmt) ? rlmt : a);
        e.data = (a > rlmt) ? {4{ram[rlmt][31:24]}} : ram[a];
      end
      exp_q.push_back(e);
    end

    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.pos_x_i     = 6'(pos);
    bus.len_i       = 5'(len);
    bus.right_lmt_i = 6'(rlmt);
    bus.top_avail_i = top;
    @(posedge clk);
    #1 bus.start_i = 1'b0;

    first = 0; words = 0; done_cyc = 0; end_cyc = 0; aborted = 1'b0; last_data = '0;
    for (int cyc = 1; cyc <= 100 && end_cyc == 0; cyc++) begin
      @(negedge clk);
      bus.start_i = (cyc == extra_cyc);
      if (cyc == extra_cyc) begin
        bus.pos_x_i = 6'd20;
        bus.len_i   = 5'd2;
      end
      if (!bus.ram_cen_o) begin
        if (addr_q.size() == 0)
          note_fail("ram_addr_extra", $sformatf("read of addr %0d, none required", bus.ram_addr_o));
        else
          chk("ram_addr", 32'(bus.ram_addr_o), 32'(addr_q.pop_front()));
      end
      if (bus.pix_valid_o) begin
        words++;
        if (first == 0) first = cyc;
        last_data = bus.pix_data_o;
        if (exp_q.size() == 0)
          note_fail("pix_extra", $sformatf("word %h idx %0d, none required", bus.pix_data_o, bus.pix_idx_o));
        else begin
          e = exp_q.pop_front();
          chk("pix_data", bus.pix_data_o, e.data);
          chk("pix_idx", 32'(bus.pix_idx_o), 32'(e.idx));
          chk("done_with_word", 32'(bus.done_o), 32'(e.last));
        end
      end
      if (bus.done_o) done_cyc = cyc;
      if (!bus.busy_o) end_cyc = cyc;
      if (rst_word != 0 && words == rst_word) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_pix_valid", 32'(bus.pix_valid_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_cen", 32'(bus.ram_cen_o), 32'd1);
        chk("rst_pix_data", bus.pix_data_o, 32'd0);
        repeat (2) begin
          @(negedge clk);
          chk("rst_hold_cen", 32'(bus.ram_cen_o), 32'd1);
          chk("rst_hold_valid", 32'(bus.pix_valid_o), 32'd0);
        end
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        aborted = 1'b1;
        end_cyc = cyc;
      end
    end

    if (end_cyc == 0) note_fail("timeout", "busy_o still high after 100 cycles, required low");
    else if (!aborted) begin
      $display("fetch pos=%0d len=%0d rlmt=%0d top=%0d: words=%0d first=%0d done=%0d end=%0d",
               pos, len, rlmt, top, words, first, done_cyc, end_cyc);
      chk("first_latency", 32'(first), 32'(exp_lat));
      chk("word_count", 32'(words), 32'(n));
      chk("done_cycle", 32'(done_cyc), 32'((n == 0) ? 1 : exp_lat + n - 1));
      chk("busy_fall", 32'(end_cyc), 32'(done_cyc + 1));
      if (n > 0) chk("last_word", last_data, exp_last);
      chk("sb_words_left", 32'(exp_q.size()), 32'd0);
      chk("sb_addr_left", 32'(addr_q.size()), 32'd0);
      repeat (3) begin
        @(negedge clk);
        chk("idle_quiet", {30'd0, bus.pix_valid_o, bus.ram_cen_o}, 32'd1);
      end
    end else begin
      $display("fetch pos=%0d len=%0d aborted by reset after %0d words", pos, len, words);
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{10, 4, 63, 1'b1, 3, 32'h0F0E0D0C};
    vecs[1] = '{30, 4, 31, 1'b1, 3, 32'hABABABAB};
    vecs[2] = '{40, 2, 35, 1'b1, 3, 32'h5A5A5A5A};
    vecs[3] = '{ 0, 16, 63, 1'b0, 1, 32'h80808080};
    vecs[4] = '{ 7, 0, 63, 1'b1, 0, 32'h00000000};
    vecs[5] = '{50, 20, 63, 1'b1, 3, 32'h7F7F7F7F};
    vecs[6] = '{ 5, 1, 63, 1'b1, 3, 32'h4505EE05};
    vecs[7] = '{63, 3, 63, 1'b1, 3, 32'h7F7F7F7F};
    vecs[8] = '{12, 1, 63, 1'b0, 1, 32'h80808080};

    for (int a = 0; a < 64; a++) ram[a] = {8'(a + 8'h40), 8'(a), 8'hEE, 8'(a)};
    for (int k = 0; k < 4; k++) ram[10 + k] = 32'h03020100 + 32'(k) * 32'h04040404;
    ram[31] = 32'hAB000000;
    ram[35] = 32'h5A112233;

    rst             = 1'b1;
    bus.start_i     = 1'b0;
    bus.pos_x_i     = '0;
    bus.len_i       = '0;
    bus.right_lmt_i = '0;
    bus.top_avail_i = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy_o), 32'd0);
    chk("reset_done", 32'(bus.done_o), 32'd0);
    chk("reset_valid", 32'(bus.pix_valid_o), 32'd0);
    chk("reset_idx", 32'(bus.pix_idx_o), 32'd0);
    chk("reset_data", bus.pix_data_o, 32'd0);
    chk("reset_cen", 32'(bus.ram_cen_o), 32'd1);
    chk("reset_addr", 32'(bus.ram_addr_o), 32'd0);
    chk("wen_tied", 32'(bus.ram_wen_o), 32'd1);
    chk("oen_tied", 32'(bus.ram_oen_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_fetch(vecs[i].pos, vecs[i].len, vecs[i].rlmt, vecs[i].top,
                vecs[i].lat, vecs[i].last, 0, 0);

    // Start pulsed mid-fetch must be ignored: exactly 8 words of the first request.
    run_fetch(0, 8, 63, 1'b1, 3, 32'h4707EE07, 4, 0);

    // Reset at the 2nd output word aborts; the next request runs normally.
    run_fetch(0, 8, 63, 1'b1, 3, 32'h4707EE07, 0, 2);
    run_fetch(vecs[0].pos, vecs[0].len, vecs[0].rlmt, vecs[0].top,
              vecs[0].lat, vecs[0].last, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intra_ref_row_fetch.md
Name: intra_ref_row_fetch

Overview:
- Read-side controller for the 32x64 LCU-row reference buffer used by intra prediction.
- On a start request, it reads up to 16 consecutive 32-bit words (4 pixels x 8 bit) of the above-row reference through the buffer's port B.
- It clamps and pads reads past the right picture edge, and substitutes the default value 8'h80 when the top row is unavailable.
- It delivers one word per cycle to the intra reference assembly stage, with a valid strobe and a word index.

Parameters:
- Word_Width, 32, RAM word width (4 pixels x 8 bit).
- Addr_Width, 6, RAM address width (64 words).
- LEN_W, 5, width of the length request (legal range 0..16).

Ports:
- clk  in  1  single clock, shared with the row buffer.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  fetch request; accepted only while busy_o=0.
- pos_x_i  in  Addr_Width  first word address.
- len_i  in  LEN_W  number of words to deliver; values 17..31 saturate to 16.
- right_lmt_i  in  Addr_Width  last in-picture word address.
- top_avail_i  in  1  1 = above row exists in the buffer.
- busy_o  out  1  fetch in progress.
- done_o  out  1  one-cycle pulse, coincident with the last word (or the empty completion).
- ram_cen_o  out  1  to buffer cenb_i; low active.
- ram_wen_o  out  1  to buffer wenb_i; tied 1 (read only).
- ram_oen_o  out  1  to buffer oenb_i; tied 0.
- ram_addr_o  out  Addr_Width  to buffer addrb_i.
- ram_data_i  in  Word_Width  from buffer datab_o.
- pix_valid_o  out  1  output word valid.
- pix_idx_o  out  4  index of the word within the request (0..15).
- pix_data_o  out  Word_Width  reference pixels; byte0 is the leftmost pixel.

Behaviour:
- Reset (async, rst=1), all held until rst falls:
  - state=IDLE.
  - busy_o=0, done_o=0, pix_valid_o=0, pix_idx_o=0, pix_data_o=0.
  - ram_cen_o=1, ram_addr_o=0.
- Reset mid-fetch: aborts immediately; no further RAM reads and no done_o.
- Accept: at the edge where start_i=1 and busy_o=0, register pos_x, len, right_lmt and top_avail.
  - busy_o rises the next cycle.
  - start_i while busy_o=1 is ignored.
- States: IDLE, READ, DRAIN, FILL.
- Transitions out of IDLE on accept:
  - len=0 -> no RAM access, no pix_valid; done_o pulses the cycle after accept, busy_o high for that one cycle, then IDLE.
  - top_avail=0 -> FILL.
  - Otherwise -> READ.
- READ issues one read per cycle for k=0..len-1:
  - ram_cen_o=0, ram_addr_o = min(pos_x+k, right_lmt).
  - The sum pos_x+k is computed in Addr_Width+1 bits, so it never wraps.
  - Word k carries a pad tag, set when pos_x+k > right_lmt.
  - After the last issue -> DRAIN with ram_cen_o=1.
- Read pipeline:
  - RAM data is valid 1 cycle after issue.
  - The output register loads on the following edge.
  - First pix_valid_o is 3 cycles after the accept edge; subsequent words come back-to-back with no gaps.
- Padded word output: {4{ram_data_i[31:24]}}, i.e. the rightmost in-picture pixel replicated.
  - Holds when every word, including word 0, is padded (pos_x > right_lmt): the clamped read of right_lmt supplies the pixel.
- Unpadded word output: pix_data_o = ram_data_i.
- DRAIN waits for the last word: done_o=1 with the last pix_valid_o, then IDLE. busy_o falls the cycle after done_o.
- FILL (top unavailable):
  - No RAM access.
  - pix_data_o=32'h80808080 for len consecutive cycles, starting the cycle after accept.
  - done_o with the last word, then IDLE.
- pix_idx_o increments 0..len-1 with each valid word.
- pix_data_o and pix_idx_o hold their last value while pix_valid_o=0.
- Simultaneous port-A write to the same address as a port-B read: the read returns the pre-write contents. The block does not forward.

Optional Feature:
- Macro INTRA_REF_ROW_CNT_EN.
- Defined:
  - Adds output rd_cnt_o [15:0], counting cycles with ram_cen_o=0.
  - Saturates at 16'hFFFF; cleared by rst only.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- In-picture fetch:
  - Stimulus: buffer words 10..13 = 32'h03020100 + k*32'h04040404; start with pos_x=10, len=4, right_lmt=63, top_avail=1.
  - Response: pix_valid_o for cycles 3..6 after accept, pix_data_o = 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, idx 0..3; done_o with idx 3.
- Right-edge pad:
  - Stimulus: pos_x=30, len=4, right_lmt=31, word31=32'hAB000000.
  - Response: addresses 30,31,31,31; words 2 and 3 = 32'hABABABAB.
- Fully padded:
  - Stimulus: pos_x=40, len=2, right_lmt=35, word35=32'h5A112233.
  - Response: both words = 32'h5A5A5A5A; ram_addr_o=35 both cycles.
- Top unavailable:
  - Stimulus: top_avail=0, len=16.
  - Response: ram_cen_o stays 1; 16 words of 32'h80808080 starting 1 cycle after accept; done_o with idx 15.
- Length 0 and busy:
  - len=0 -> done_o 1 cycle after accept, no pix_valid.
  - A start pulsed during a busy fetch (len=8) is ignored; exactly 8 words are delivered.
- Reset mid-fetch:
  - Stimulus: assert rst at the 2nd output word of len=8.
  - Response: pix_valid_o, busy_o and done_o drop immediately; ram_cen_o=1; a new start after reset completes normally.
